// File: rtl/ldm_writeback_sequencer.sv
// ldm_writeback_sequencer: serialises LDM memory reads into register-file writes, one per set list bit.
// Optional base-register writeback is enabled by defining LDM_BASE_WRITEBACK_EN.
module ldm_writeback_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int MOC_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              up,
  input  logic              wb,
  input  logic [3:0]        base_reg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_data,
  input  logic              mem_moc,
  output logic [3:0]        rf_c,
  output logic [31:0]       rf_pc,
  output logic              rf_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
`ifdef LDM_BASE_WRITEBACK_EN
    WBASE,
`endif
    FIN,
    ABORT
  } state_t;
  localparam logic [7:0] TO_LAST = 8'(MOC_TIMEOUT - 1);
  state_t            state, nxt;
  logic [15:0]       list, rest;
  logic [ADDR_W-1:0] addr, addr_d, step, start_addr;
  logic [7:0]        cnt;
  logic [4:0]        n;
  logic [3:0]        low;
  logic              go, timeout;
`ifdef LDM_BASE_WRITEBACK_EN
  logic              wb_en;
  logic [3:0]        base_reg_q;
  logic [ADDR_W-1:0] wb_val;
`else
  logic              unused_ok;
  assign unused_ok = ^{wb, base_reg};
`endif
  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(reg_list[i]);
    low = '0;
    for (int i = 15; i >= 0; i--) if (list[i]) low = 4'(i);
  end
  assign step       = ADDR_W'({n, 2'b00});
  assign start_addr = up ? base_addr : base_addr - step;
  assign rest       = list & (list - 16'd1);
  assign go         = state == IDLE && start;
  assign timeout    = !mem_moc && cnt == TO_LAST;
  assign addr_d     = go ? start_addr : state == WRITE ? addr + ADDR_W'(4) : addr;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? (reg_list != '0 ? REQ : FIN) : IDLE;
      REQ:   nxt = mem_moc ? WRITE : timeout ? ABORT : REQ;
`ifdef LDM_BASE_WRITEBACK_EN
      WRITE: nxt = rest != '0 ? REQ : wb_en ? WBASE : FIN;
      WBASE: nxt = FIN;
`else
      WRITE: nxt = rest != '0 ? REQ : FIN;
`endif
      default: nxt = IDLE;
    endcase
  end
  assign mem_rd = state == REQ;
`ifdef LDM_BASE_WRITEBACK_EN
  assign rf_enable = state == WRITE || state == WBASE;
`else
  assign rf_enable = state == WRITE;
`endif
  assign busy  = state != IDLE;
  assign done  = state == FIN;
  assign error = state == ABORT;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      list     <= '0;
      addr     <= '0;
      cnt      <= '0;
      mem_addr <= '0;
      rf_c     <= '0;
      rf_pc    <= '0;
`ifdef LDM_BASE_WRITEBACK_EN
      wb_en      <= 1'b0;
      base_reg_q <= '0;
      wb_val     <= '0;
`endif
    end else begin
      state <= nxt;
      addr  <= addr_d;
      list  <= go ? reg_list : state == WRITE ? rest : list;
      cnt   <= state == REQ && !mem_moc ? cnt + 8'd1 : '0;
      if (nxt == REQ) mem_addr <= addr_d;
      // mem_data is captured on the same edge that sees mem_moc
      if (nxt == WRITE) begin
        rf_c  <= low;
        rf_pc <= mem_data;
      end
`ifdef LDM_BASE_WRITEBACK_EN
      if (nxt == WBASE) begin
        rf_c  <= base_reg_q;
        rf_pc <= 32'(wb_val);
      end
      // a base register that is also in the list keeps its loaded value
      if (go) begin
        wb_en      <= wb && !reg_list[base_reg];
        base_reg_q <= base_reg;
        wb_val     <= up ? base_addr + step : start_addr;
      end
`endif
    end
  end
endmodule
